conversor7seg_param: RTL and testbench
======================================

CONVERSOR7SEG_PARAM -- requirements
Module: conversor7seg_param

Interface
REQ-001 Parameter: WIDTH, default 8, binary input width (4..16).
REQ-002 Parameter: DIGITS, default 4, number of display digits (1..8).
REQ-003 Parameter: PRESCALE, default 50000, clock cycles each digit stays enabled (>=2).
REQ-004 Parameter: BLANK_ZEROS, default 1, 1 = blank leading zeros.
REQ-005 clock  in  1  single system clock, all logic on rising edge.
REQ-006 zera_as_n  in  1  reset, asynchronous assert, active-low.
REQ-007 numero  in  WIDTH  unsigned binary value to display.
REQ-008 carrega  in  1  load strobe, samples numero when idle.
REQ-009 ocupado  out  1  high while a conversion is in progress.
REQ-010 pronto  out  1  one-cycle pulse when a conversion completes.
REQ-011 overflow  out  1  value needs more than DIGITS decimal digits (held until next completion).
REQ-012 an  out  DIGITS  digit enables, active-low, one-hot-low while scanning.
REQ-013 seg  out  8  segments, active-low, order {dp,g,f,e,d,c,b,a}; dp always 1.

Function
REQ-014 FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on carrega, SHIFT->DONE after WIDTH shift cycles, DONE->IDLE unconditionally.
REQ-015 Conversion uses shift-add-3 (double dabble), one bit per clock, over NBCD = ceil(WIDTH*log10(2)) BCD digits.
REQ-016 pronto asserts exactly WIDTH+1 cycles after the carrega sample edge; ocupado is high from the cycle after that edge through the pronto cycle.
REQ-017 carrega while ocupado is ignored; numero is not re-sampled.
REQ-018 Displayed digit registers and overflow update only in DONE (no partial/torn values shown during SHIFT).
REQ-019 overflow = 1 when any BCD digit at index >= DIGITS is nonzero; then every digit shows dash (8'hBF).
REQ-020 Blanking: with BLANK_ZEROS=1, zero digits above the most significant nonzero digit show 8'hFF; digit 0 always shown (value 0 displays "0").
REQ-021 Prescaler counts 0..PRESCALE-1 continuously; at terminal count the scan index advances 0..DIGITS-1, wrapping to 0.
REQ-022 an[i]=0 only when scan index = i; index 0 is the least significant digit.
REQ-023 seg is a registered function of scan index and displayed digit; an and seg change on the same edge.
REQ-024 Digit encoding 0..9 per standard active-low table (0=8'hC0 ... 9=8'h90); BCD codes 10..15 never displayed.
REQ-025 Scanning continues unaffected by conversions; no cycle has two an bits low.

Reset
REQ-026 While zera_as_n=0: state IDLE, ocupado=0, pronto=0, overflow=0, an all 1, seg=8'hFF, prescaler=0, scan index=0, displayed digits=0.
REQ-027 Reset during SHIFT aborts the conversion; no pronto is issued; first carrega after release converts normally.
REQ-028 After release, first digit enable (an[0]=0, seg shows "0") appears on the first prescaler terminal count.

Structure
REQ-029 Package conversor7seg_pkg holds state enum, SEG_BLANK=8'hFF, SEG_DASH=8'hBF, digit-to-segment table, and NBCD computation function.
REQ-030 Sub-module bin2bcd_seq implements REQ-014..REQ-017 (start/busy/done handshake, WIDTH, NBCD params); top holds scan, blanking, encoding.

Verification (WIDTH=8, DIGITS=3, PRESCALE=4 unless stated)
REQ-031 carrega with numero=255 -> pronto at cycle +9; digits 2,5,5; overflow=0.
REQ-032 numero=7 -> an cycles 110,101,011 four clocks each; seg 8'hF8, 8'hFF, 8'hFF; numero=0 -> 8'hC0, 8'hFF, 8'hFF.
REQ-033 carrega 100 then carrega 42 two cycles later -> single pronto, display 1,0,0.
REQ-034 DIGITS=2, numero=200 -> overflow=1, both digits 8'hBF; then numero=99 -> overflow=0, display 9,9.
REQ-035 zera_as_n low at SHIFT cycle 4 -> immediate reset values, no pronto; reload 128 -> display 1,2,8 after 9 cycles.

Source files
------------

// File: rtl/conversor7seg_pkg.sv
// Shared types, segment constants and sizing helpers for the multiplexed
// binary-to-7-segment converter.
package conversor7seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Active-low {dp,g,f,e,d,c,b,a}; codes above 9 never reach the display.
  function automatic logic [7:0] digit_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_to_seg = 8'hC0;
      4'd1:    digit_to_seg = 8'hF9;
      4'd2:    digit_to_seg = 8'hA4;
      4'd3:    digit_to_seg = 8'hB0;
      4'd4:    digit_to_seg = 8'h99;
      4'd5:    digit_to_seg = 8'h92;
      4'd6:    digit_to_seg = 8'h82;
      4'd7:    digit_to_seg = 8'hF8;
      4'd8:    digit_to_seg = 8'h80;
      4'd9:    digit_to_seg = 8'h90;
      default: digit_to_seg = SEG_BLANK;
    endcase
  endfunction

  // Decimal digits of 2^width-1, which equals ceil(width*log10(2)).
  function automatic int calc_nbcd(input int width);
    int v;
    int n;
    v = (1 << width) - 1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (v > 0) begin
        n = n + 1;
        v = v / 10;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per clock.
// Handshake: start_i is sampled only while idle and not busy; busy_o is high
// from the cycle after the sample edge through the done_o pulse cycle.
module bin2bcd_seq
  import conversor7seg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NBCD  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [WIDTH-1:0]  bin_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [4*NBCD-1:0] bcd_o,
  output state_t            state_o
);

  localparam int CW = $clog2(WIDTH);

  state_t            state_q;
  logic [WIDTH-1:0]  bin_q;
  logic [4*NBCD-1:0] bcd_q;
  logic [4*NBCD-1:0] bcd_adj;
  logic [CW-1:0]     cnt_q;
  logic              busy_q;
  logic              done_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NBCD; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // busy stays up for the pronto cycle, so a strobe there is dropped
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (start_i) begin
            bin_q   <= bin_i;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd_q <= {bcd_adj[4*NBCD-2:0], bin_q[WIDTH-1]};
          bin_q <= {bin_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign bcd_o   = bcd_q;
  assign state_o = state_q;

endmodule

// File: rtl/conversor7seg_param.sv
// Binary value to multiplexed 7-segment display: sequential BCD conversion,
// leading-zero blanking, overflow dashes and a prescaled digit scan.
module conversor7seg_param
  import conversor7seg_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned PRESCALE    = 50000,
  parameter bit          BLANK_ZEROS = 1'b1
) (
  input  logic              clock,
  input  logic              zera_as_n,
  input  logic [WIDTH-1:0]  numero,
  input  logic              carrega,
  output logic              ocupado,
  output logic              pronto,
  output logic              overflow,
  output logic [DIGITS-1:0] an,
  output logic [7:0]        seg
);

  localparam int NBCD = calc_nbcd(WIDTH);
  localparam int PADN = (NBCD > DIGITS) ? NBCD : DIGITS;
  localparam int PW   = $clog2(PRESCALE);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*NBCD-1:0] bcd;
  logic [4*PADN-1:0] bcd_pad;
  state_t            conv_state;
  logic              conv_busy;
  logic              conv_done;

  bin2bcd_seq #(.WIDTH(WIDTH), .NBCD(NBCD)) u_conv (
    .clk     (clock),
    .rst_n   (zera_as_n),
    .start_i (carrega),
    .bin_i   (numero),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (bcd),
    .state_o (conv_state)
  );

  assign ocupado = conv_busy;
  assign pronto  = conv_done;
  assign bcd_pad = (4*PADN)'(bcd);

  logic [3:0] disp_q [DIGITS];
  logic       ovf_q;

  // Display latches the finished BCD only in DONE, never a partial shift.
  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      for (int i = 0; i < DIGITS; i++) disp_q[i] <= 4'd0;
      ovf_q <= 1'b0;
    end else if (conv_state == ST_DONE) begin
      for (int i = 0; i < DIGITS; i++) disp_q[i] <= bcd_pad[4*i +: 4];
      ovf_q <= |(bcd_pad >> (4*DIGITS));
    end
  end

  assign overflow = ovf_q;

  logic [PW-1:0]     pre_q;
  logic [IW-1:0]     idx_q, idx_d;
  logic              active_q, active_d;
  logic              tick;
  logic [DIGITS-1:0] blank;
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0]        seg_q, seg_d;

  assign tick = (pre_q == PW'(PRESCALE - 1));

  always_comb begin
    logic seen;
    seen  = 1'b0;
    blank = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      seen     = seen | (disp_q[i] != 4'd0);
      blank[i] = BLANK_ZEROS && !seen;
    end
  end

  // The first terminal count only enables digit 0; later ones advance.
  always_comb begin
    active_d = active_q | tick;
    idx_d    = idx_q;
    if (tick && active_q) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    an_d = active_d ? ~(DIGITS'(1) << idx_d) : '1;
    if (!active_d)       seg_d = SEG_BLANK;
    else if (ovf_q)      seg_d = SEG_DASH;
    else if (blank[idx_d]) seg_d = SEG_BLANK;
    else                 seg_d = digit_to_seg(disp_q[idx_d]);
  end

  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      pre_q    <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
      an_q     <= '1;
      seg_q    <= SEG_BLANK;
    end else begin
      pre_q    <= tick ? '0 : pre_q + PW'(1);
      idx_q    <= idx_d;
      active_q <= active_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_conversor7seg_param.sv
// Bench for conversor7seg_param: a 3-digit and a 2-digit instance share one
// stimulus stream and are checked every cycle against a decimal-arithmetic model.
module tb_conversor7seg_param;

  localparam int PRE = 4;

  // clock/reset block
  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] numero = 8'd0;
  logic       carrega = 1'b0;

  always #5 clock = ~clock;

  logic       ocupado_a, pronto_a, overflow_a;
  logic [2:0] an_a;
  logic [7:0] seg_a;
  logic       ocupado_b, pronto_b, overflow_b;
  logic [1:0] an_b;
  logic [7:0] seg_b;

  conversor7seg_param #(.WIDTH(8), .DIGITS(3), .PRESCALE(PRE), .BLANK_ZEROS(1'b1)) dut_a (
    .clock(clock), .zera_as_n(rst_n), .numero(numero), .carrega(carrega),
    .ocupado(ocupado_a), .pronto(pronto_a), .overflow(overflow_a), .an(an_a), .seg(seg_a)
  );

  conversor7seg_param #(.WIDTH(8), .DIGITS(2), .PRESCALE(PRE), .BLANK_ZEROS(1'b1)) dut_b (
    .clock(clock), .zera_as_n(rst_n), .numero(numero), .carrega(carrega),
    .ocupado(ocupado_b), .pronto(pronto_b), .overflow(overflow_b), .an(an_b), .seg(seg_b)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [7:0] exp_seg(input int v, input int d, input int idx);
    if (v >= pow10(d)) return 8'hBF;
    if (idx > 0 && v < pow10(idx)) return 8'hFF;
    return seg_tab[(v / pow10(idx)) % 10];
  endfunction

  int         m_cnt = 0;   // cycles since the accepted strobe, 0 = idle
  int         m_val = 0;
  int         m_disp = 0;
  int         m_k = 0;     // clock edges since reset release
  logic [2:0] e_an_a = 3'b111;
  logic [1:0] e_an_b = 2'b11;
  logic [7:0] e_seg_a = 8'hFF;
  logic [7:0] e_seg_b = 8'hFF;

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_val = 0; m_disp = 0; m_k = 0;
      e_an_a = 3'b111; e_an_b = 2'b11; e_seg_a = 8'hFF; e_seg_b = 8'hFF;
    end else begin
      m_k++;
      if (m_k >= PRE) begin
        e_an_a  = ~(3'b001 << (((m_k / PRE) - 1) % 3));
        e_an_b  = ~(2'b01 << (((m_k / PRE) - 1) % 2));
        e_seg_a = exp_seg(m_disp, 3, ((m_k / PRE) - 1) % 3);
        e_seg_b = exp_seg(m_disp, 2, ((m_k / PRE) - 1) % 2);
      end
      if (m_cnt > 0) begin
        if (m_cnt == 10) m_cnt = 0;
        else begin
          m_cnt++;
          if (m_cnt == 10) m_disp = m_val;
        end
      end else if (carrega) begin
        m_cnt = 1;
        m_val = numero;
      end
    end
  end

  // scoreboard compare, every cycle on the falling edge
  always @(negedge clock) begin
    chk("ocupado_a", 16'(ocupado_a), 16'(m_cnt != 0));
    chk("pronto_a", 16'(pronto_a), 16'(m_cnt == 10));
    chk("overflow_a", 16'(overflow_a), 16'(m_disp >= 1000));
    chk("an_a", 16'(an_a), 16'(e_an_a));
    chk("seg_a", 16'(seg_a), 16'(e_seg_a));
    chk("ocupado_b", 16'(ocupado_b), 16'(m_cnt != 0));
    chk("pronto_b", 16'(pronto_b), 16'(m_cnt == 10));
    chk("overflow_b", 16'(overflow_b), 16'(m_disp >= 100));
    chk("an_b", 16'(an_b), 16'(e_an_b));
    chk("seg_b", 16'(seg_b), 16'(e_seg_b));
  end

  // driver tasks
  task automatic load(input logic [7:0] v);
    @(posedge clock); #2;
    numero = v; carrega = 1'b1;
    @(posedge clock); #2;
    carrega = 1'b0;
  endtask

  task automatic settle();
    repeat (12) @(posedge clock);
  endtask

  task automatic scan_a(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0] e [3];
    logic [2:0] pat;
    bit found;
    e[0] = e0; e[1] = e1; e[2] = e2;
    for (int idx = 0; idx < 3; idx++) begin
      pat = ~(3'b001 << idx);
      found = 0;
      for (int n = 0; n < 40 && !found; n++) begin
        @(negedge clock);
        if (an_a == pat) found = 1;
      end
      if (!found) chk("scan_a_wait", 16'(an_a), 16'(pat));
      else chk("scan_a_lit", 16'(seg_a), 16'(e[idx]));
    end
  endtask

  task automatic scan_b(input logic [7:0] e0, input logic [7:0] e1);
    logic [7:0] e [2];
    logic [1:0] pat;
    bit found;
    e[0] = e0; e[1] = e1;
    for (int idx = 0; idx < 2; idx++) begin
      pat = ~(2'b01 << idx);
      found = 0;
      for (int n = 0; n < 40 && !found; n++) begin
        @(negedge clock);
        if (an_b == pat) found = 1;
      end
      if (!found) chk("scan_b_wait", 16'(an_b), 16'(pat));
      else chk("scan_b_lit", 16'(seg_b), 16'(e[idx]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;
    logic [7:0] corners [6];
    corners = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd255};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_an_a", 16'(an_a), 16'h0007);
    chk("rst_seg_a", 16'(seg_a), 16'h00FF);
    chk("rst_ocupado", 16'(ocupado_a), 16'h0000);

    @(posedge clock); #2;
    rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      @(posedge clock); #1;
      if (an_a != 3'b111) n = i;
    end
    chk("first_scan_edge", 16'(n), 16'd4);
    chk("first_scan_seg", 16'(seg_a), 16'h00C0);

    // 255: pronto nine edges after the sample edge
    @(posedge clock); #2;
    numero = 8'd255; carrega = 1'b1;
    @(posedge clock); #2;
    carrega = 1'b0;
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      @(posedge clock); #1;
      if (pronto_a) n = i;
    end
    chk("pronto_latency", 16'(n), 16'd9);
    scan_a(8'h92, 8'h92, 8'hA4);
    chk("ovf_a_255", 16'(overflow_a), 16'h0000);
    scan_b(8'hBF, 8'hBF);

    load(8'd7);   settle(); scan_a(8'hF8, 8'hFF, 8'hFF);
    load(8'd0);   settle(); scan_a(8'hC0, 8'hFF, 8'hFF);

    // second strobe while busy is ignored
    load(8'd100);
    @(posedge clock); #2;
    numero = 8'd42; carrega = 1'b1;
    @(posedge clock); #2;
    carrega = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (pronto_a) pulses++;
    end
    chk("single_pronto", 16'(pulses), 16'd1);
    scan_a(8'hC0, 8'hC0, 8'hF9);

    load(8'd200); settle();
    chk("ovf_b_200", 16'(overflow_b), 16'h0001);
    scan_b(8'hBF, 8'hBF);
    load(8'd99); settle();
    chk("ovf_b_99", 16'(overflow_b), 16'h0000);
    scan_b(8'h90, 8'h90);
    scan_a(8'h90, 8'h90, 8'hFF);

    // reset in the middle of a conversion
    load(8'd77);
    repeat (3) @(posedge clock);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ocupado", 16'(ocupado_a), 16'h0000);
    chk("abort_an", 16'(an_a), 16'h0007);
    chk("abort_seg", 16'(seg_a), 16'h00FF);
    repeat (2) @(posedge clock);
    #2;
    rst_n = 1'b1;
    load(8'd128); settle();
    scan_a(8'h80, 8'hA4, 8'hF9);

    // randomized traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      @(posedge clock); #2;
      rst_n = ($urandom_range(0, 149) != 0);
      carrega = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) numero = corners[$urandom_range(0, 5)];
      else numero = 8'($urandom_range(0, 255));
    end
    @(posedge clock); #2;
    rst_n = 1'b1; carrega = 1'b0;
    repeat (30) @(posedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
